// File: rtl/hpdl1414_pkg.sv
// hpdl1414_pkg
// Shared types and constants for the HPDL-1414 scan driver slice.
//   state_t          : scan FSM states
//   NUM_CHARS        : characters held in the display buffer
//   CHARS_PER_DISPLAY: digits on one HPDL-1414 device
//   NUM_DISPLAYS     : devices on the Pmod
//   HPDL_*           : character-set limits and blank code
package hpdl1414_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STROBE = 3'd3,
    ST_HOLD   = 3'd4
  } state_t;

  localparam int NUM_CHARS         = 16;
  localparam int CHARS_PER_DISPLAY = 4;
  localparam int NUM_DISPLAYS      = 4;

  localparam logic [6:0] HPDL_SPACE   = 7'h20;
  localparam logic [6:0] HPDL_MIN_CHR = 7'h20;
  localparam logic [6:0] HPDL_MAX_CHR = 7'h5F;

endpackage

// File: rtl/hpdl1414_char_map.sv
// hpdl1414_char_map
// Combinational sanitiser from a buffer byte to the HPDL-1414 7-bit code set.
// Codes 0x20..0x5F pass through; everything else becomes a space.
// Build option HPDL_CASE_FOLD_EN: lowercase 0x61..0x7A fold to uppercase.
// Ports:
//   i_byte : raw buffer byte (8 bits)
//   o_char : displayable code (7 bits)
module hpdl1414_char_map
  import hpdl1414_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [6:0] o_char
);

  always_comb begin
    o_char = HPDL_SPACE;
    // Range check is done on the full byte so bit 7 can never alias into range.
    if ((i_byte >= {1'b0, HPDL_MIN_CHR}) && (i_byte <= {1'b0, HPDL_MAX_CHR})) begin
      o_char = i_byte[6:0];
    end
`ifdef HPDL_CASE_FOLD_EN
    else if ((i_byte >= 8'h61) && (i_byte <= 8'h7A)) begin
      o_char = i_byte[6:0] - 7'h20;
    end
`else
    else begin
      o_char = HPDL_SPACE;
    end
`endif
  end

endmodule

// File: rtl/hpdl1414_scan_driver.sv
// hpdl1414_scan_driver
// Continuous refresh engine: walks buffer addresses 0..15, fetches each byte
// over a one-cycle-latency read port, sanitises it and writes it into the
// right HPDL-1414 digit with a setup / write-strobe / hold sequence. Also
// runs the free-running caret blink counter.
// Build option HPDL_CASE_FOLD_EN (tested in hpdl1414_char_map only).
// Ports:
//   i_clk, i_reset   : clock, synchronous active-high reset
//   o_read_enable    : one-cycle buffer read request
//   o_read_address   : buffer index being fetched
//   i_read_data      : buffer byte, valid the cycle after o_read_enable
//   o_caret_strobe   : blink phase (MSB of blink counter)
//   o_hpdl_data      : shared D6..D0 bus
//   o_hpdl_addr      : shared A1..A0 digit select
//   o_hpdl_wr_n      : per-display active-low write strobe
//   o_frame_done     : one-cycle pulse after the last character's hold
// Handshake: the buffer read is fire-and-forget; o_read_enable is a single
// cycle pulse and i_read_data is consumed exactly one cycle later, never
// at any other time.
module hpdl1414_scan_driver
  import hpdl1414_pkg::*;
#(
  parameter int PHASE_CYCLES = 12,
  parameter int BLINK_BITS   = 22
) (
  input  logic       i_clk,
  input  logic       i_reset,
  output logic       o_read_enable,
  output logic [3:0] o_read_address,
  input  logic [7:0] i_read_data,
  output logic       o_caret_strobe,
  output logic [6:0] o_hpdl_data,
  output logic [1:0] o_hpdl_addr,
  output logic [3:0] o_hpdl_wr_n,
  output logic       o_frame_done
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PHASE_CYCLES - 1);

  state_t                state, state_next;
  logic [CNT_W-1:0]      phase_cnt;
  logic                  phase_last;
  logic [3:0]            idx;
  logic                  holdoff_q;
  logic [6:0]            data_q;
  logic [6:0]            mapped;
  logic [1:0]            addr_q;
  logic                  frame_done_q;
  logic [BLINK_BITS-1:0] blink_q;
  logic [3:0]            wr_n;

  hpdl1414_char_map u_char_map (
    .i_byte (i_read_data),
    .o_char (mapped)
  );

  assign phase_last = (phase_cnt == PH_LAST);

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      // holdoff_q keeps FETCH parked for the edge that releases reset, so the
      // read pulse lands in the first cycle after reset deasserts.
      ST_FETCH:  if (!holdoff_q) state_next = ST_LATCH;
      ST_LATCH:  state_next = ST_SETUP;
      ST_SETUP:  if (phase_last) state_next = ST_STROBE;
      ST_STROBE: if (phase_last) state_next = ST_HOLD;
      ST_HOLD:   if (phase_last) state_next = ST_FETCH;
      default:   state_next = ST_FETCH;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= ST_FETCH;
      phase_cnt    <= '0;
      idx          <= 4'd0;
      holdoff_q    <= 1'b1;
      data_q       <= HPDL_SPACE;
      addr_q       <= 2'd3;
      frame_done_q <= 1'b0;
      blink_q      <= '0;
    end else begin
      holdoff_q <= 1'b0;
      blink_q   <= blink_q + BLINK_BITS'(1);
      state     <= state_next;
      phase_cnt <= (state_next != state) ? '0 : phase_cnt + CNT_W'(1);
      if (state == ST_LATCH) begin
        data_q <= mapped;
        // Digit 3 is the leftmost on the device, so buffer order is reversed.
        addr_q <= 2'd3 - idx[1:0];
      end
      frame_done_q <= (state == ST_HOLD) && phase_last && (idx == 4'd15);
      if ((state == ST_HOLD) && phase_last) idx <= idx + 4'd1;
    end
  end

  // Write strobe decoded from registered state only: one display at a time.
  always_comb begin
    wr_n = 4'hF;
    if (state == ST_STROBE) wr_n[idx[3:2]] = 1'b0;
  end

  assign o_read_enable  = (state == ST_FETCH) && !holdoff_q;
  assign o_read_address = idx;
  assign o_hpdl_data    = data_q;
  assign o_hpdl_addr    = addr_q;
  assign o_hpdl_wr_n    = wr_n;
  assign o_frame_done   = frame_done_q;
  assign o_caret_strobe = blink_q[BLINK_BITS-1];

endmodule
